demux8_1to4_buf: RTL and testbench
==================================

Name: demux8_1to4_buf

Overview:
- Routes one 8-bit input stream to one of four output channels: the distributing counterpart of the 4-to-1 byte selector.
- Each output channel holds one registered entry with a valid/ready handshake.
- The destination is taken either from SEL or from an internal round-robin pointer.
- The block feeds the four per-lane consumers on the CPU datapath side. A per-channel delivery counter is provided for debug and verification.

Parameters:
- WIDTH, 8, data width of the input and of each output channel.
- CNT_W, 8, width of each per-channel accepted-word counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST_N  input  1  reset, asynchronous and active-low.
- SEL  input  2  destination channel when AUTO=0.
- AUTO  input  1  1 = round-robin destination; SEL is ignored.
- D_IN  input  WIDTH  input data word.
- IN_VALID  input  1  D_IN is valid.
- IN_READY  output  1  block can accept D_IN this cycle.
- D_OUT0..D_OUT3  output  WIDTH each  channel data registers.
- OUT_VALID  output  4  bit i: D_OUTi holds an undelivered word.
- OUT_READY  input  4  bit i: consumer i takes D_OUTi this cycle.
- RR_PTR  output  2  current round-robin pointer.
- CNT  output  4*CNT_W  accepted-word counters; channel i occupies bits [i*CNT_W +: CNT_W].

Behaviour:
- Reset (RST_N=0, asynchronous, no clock needed): OUT_VALID=0, D_OUT0..3=0, RR_PTR=0, CNT=0. IN_READY=0 while reset is asserted.
- Reset mid-operation discards all held words immediately. After RST_N rises, the first accept is possible on the first clock edge.
- Target channel T = AUTO ? RR_PTR : SEL. T is evaluated combinationally every cycle and is not latched while IN_VALID waits.
- Drain of channel i (per cycle): drain_i = OUT_VALID[i] & OUT_READY[i].
- IN_READY = !OUT_VALID[T] | OUT_READY[T]. This is a combinational path from OUT_READY, SEL, AUTO and RR_PTR. Pass-through in the same cycle is allowed: a full slot that is draining can be reloaded.
- Accept = IN_VALID & IN_READY. On the edge, D_OUT_T <= D_IN, OUT_VALID[T] <= 1, CNT_T <= CNT_T + 1 (wraps modulo 2^CNT_W, no saturation).
- Latency: a word accepted at edge k appears on D_OUT_T with OUT_VALID[T]=1 immediately after edge k. There is no combinational data path from D_IN to D_OUT.
- On drain_i without an accept to i: OUT_VALID[i] <= 0. D_OUTi holds its last value and is not cleared.
- On drain_i with an accept to i in the same cycle: OUT_VALID[i] stays 1 and D_OUTi takes the new word.
- Channels are independent: drains on any set of channels can coincide with an accept to a different channel.
- RR_PTR advances by 1 (mod 4, 3 wraps to 0) on each accept while AUTO=1. It holds on stalls and whenever AUTO=0.
- Toggling AUTO does not reset RR_PTR; round-robin resumes from the held pointer.
- IN_VALID=0: no state change except drains. Word ordering is preserved per channel only.
- No X propagation: every register has a defined reset value and an explicit hold condition.

Test Plan:
- Reset/idle: hold RST_N=0 for 3 cycles, then release with IN_VALID=0 -> OUT_VALID=0000, D_OUT0..3=00, RR_PTR=0, CNT=0, IN_READY=1.
- Directed routing: AUTO=0, OUT_READY=0, send 0x12 with SEL=0, 0x11 with SEL=1, 0x00 with SEL=2, 0x10 with SEL=3 on consecutive cycles -> D_OUT0..3=12/11/00/10, OUT_VALID=1111, each channel count=1; a 5th word 0x55 with SEL=2 sees IN_READY=0 and is held.
- Backpressure release and pass-through: continuing from the previous test, raise OUT_READY[2] with 0x55 still offered -> IN_READY=1, accepted on that edge, D_OUT2=55, OUT_VALID[2] stays 1, channel-2 count=2; other channels unchanged.
- Round-robin: AUTO=1, OUT_READY=1111, stream 0xA0..0xA5 back to back -> words land on channels 0,1,2,3,0,1; RR_PTR ends at 2; channel counts = 2,2,1,1.
- Round-robin stall and mode switch: AUTO=1 with RR_PTR=1, OUT_VALID[1]=1, OUT_READY[1]=0 -> IN_READY=0 and RR_PTR holds; switch to AUTO=0 with SEL=3 -> word accepted to channel 3 and RR_PTR stays 1.
- Async reset mid-stream and counter wrap: assert RST_N between clock edges while OUT_VALID=1111 -> outputs clear without waiting for a clock edge. After release, send 256 words to channel 0 -> channel-0 count wraps to 0x00.

Source files
------------

// File: rtl/demux8_1to4_buf.sv
// 1-to-4 byte distributor with one registered slot per channel, SEL or round-robin steering.
// Words appear one edge after acceptance; IN_READY follows the target slot's space or its same-cycle drain.
module demux8_1to4_buf #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [1:0]         SEL,
  input  logic               AUTO,
  input  logic [WIDTH-1:0]   D_IN,
  input  logic               IN_VALID,
  output logic               IN_READY,
  output logic [WIDTH-1:0]   D_OUT0,
  output logic [WIDTH-1:0]   D_OUT1,
  output logic [WIDTH-1:0]   D_OUT2,
  output logic [WIDTH-1:0]   D_OUT3,
  output logic [3:0]         OUT_VALID,
  input  logic [3:0]         OUT_READY,
  output logic [1:0]         RR_PTR,
  output logic [4*CNT_W-1:0] CNT
);

  logic [WIDTH-1:0] dat_q [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [3:0]       vld_q;
  logic [1:0]       ptr_q;
  logic [1:0]       tgt;
  logic             in_rdy;
  logic             accept;
  logic [3:0]       acc;

  // Target is re-evaluated every cycle, so a stalled word may be steered elsewhere.
  always_comb begin
    tgt    = AUTO ? ptr_q : SEL;
    in_rdy = RST_N & (~vld_q[tgt] | OUT_READY[tgt]);
    accept = IN_VALID & in_rdy;
    acc    = '0;
    for (int i = 0; i < 4; i++) begin
      acc[i] = accept && (tgt == 2'(i));
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vld_q <= '0;
      ptr_q <= '0;
      for (int i = 0; i < 4; i++) begin
        dat_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          dat_q[i] <= D_IN;
          vld_q[i] <= 1'b1;
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end else if (vld_q[i] && OUT_READY[i]) begin
          vld_q[i] <= 1'b0;
        end
      end
      if (accept && AUTO) begin
        ptr_q <= ptr_q + 2'd1;
      end
    end
  end

  always_comb begin
    CNT = '0;
    for (int i = 0; i < 4; i++) begin
      CNT[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign IN_READY  = in_rdy;
  assign OUT_VALID = vld_q;
  assign RR_PTR    = ptr_q;
  assign D_OUT0    = dat_q[0];
  assign D_OUT1    = dat_q[1];
  assign D_OUT2    = dat_q[2];
  assign D_OUT3    = dat_q[3];

endmodule

// File: tb/tb_demux8_1to4_buf.sv
// Directed bench for demux8_1to4_buf: routing, pass-through, round-robin, stall, async reset, counter wrap.
module tb_demux8_1to4_buf;

  logic        CLK;
  logic        RST_N;
  logic [1:0]  SEL;
  logic        AUTO;
  logic [7:0]  D_IN;
  logic        IN_VALID;
  logic        IN_READY;
  logic [7:0]  D_OUT0, D_OUT1, D_OUT2, D_OUT3;
  logic [3:0]  OUT_VALID;
  logic [3:0]  OUT_READY;
  logic [1:0]  RR_PTR;
  logic [31:0] CNT;

  int n_chk;
  int n_fail;

  demux8_1to4_buf #(.WIDTH(8), .CNT_W(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .SEL(SEL), .AUTO(AUTO), .D_IN(D_IN),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .D_OUT0(D_OUT0), .D_OUT1(D_OUT1), .D_OUT2(D_OUT2), .D_OUT3(D_OUT3),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .RR_PTR(RR_PTR), .CNT(CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] dir_dat [4];
  logic [7:0] rr_exp;
  logic [1:0] ch;

  initial begin
    n_chk = 0;
    n_fail = 0;
    dir_dat[0] = 8'h12; dir_dat[1] = 8'h11; dir_dat[2] = 8'h00; dir_dat[3] = 8'h10;
    RST_N = 1'b0; SEL = 2'd0; AUTO = 1'b0; D_IN = 8'h00; IN_VALID = 1'b0; OUT_READY = 4'h0;

    // Reset / idle
    repeat (3) step();
    check("rst_in_ready", {63'd0, IN_READY}, 64'd0);
    RST_N = 1'b1;
    #1;
    check("idle_valid", {60'd0, OUT_VALID}, 64'h0);
    check("idle_dout", {32'd0, D_OUT3, D_OUT2, D_OUT1, D_OUT0}, 64'h0);
    check("idle_ptr", {62'd0, RR_PTR}, 64'd0);
    check("idle_cnt", {32'd0, CNT}, 64'd0);
    check("idle_in_ready", {63'd0, IN_READY}, 64'd1);

    // Directed routing with no consumers ready
    for (int i = 0; i < 4; i++) begin
      SEL = 2'(i); D_IN = dir_dat[i]; IN_VALID = 1'b1;
      step();
    end
    SEL = 2'd2; D_IN = 8'h55;
    #1;
    check("dir_dout", {32'd0, D_OUT3, D_OUT2, D_OUT1, D_OUT0}, 64'h10001112);
    check("dir_valid", {60'd0, OUT_VALID}, 64'hF);
    check("dir_cnt", {32'd0, CNT}, 64'h01010101);
    check("dir_full_rdy", {63'd0, IN_READY}, 64'd0);
    step();
    check("dir_held_dout2", {56'd0, D_OUT2}, 64'h00);
    check("dir_held_cnt", {32'd0, CNT}, 64'h01010101);

    // Pass-through into a draining full slot
    OUT_READY = 4'b0100;
    #1;
    check("pt_rdy", {63'd0, IN_READY}, 64'd1);
    step();
    check("pt_dout", {32'd0, D_OUT3, D_OUT2, D_OUT1, D_OUT0}, 64'h10551112);
    check("pt_valid", {60'd0, OUT_VALID}, 64'hF);
    check("pt_cnt", {32'd0, CNT}, 64'h01020101);

    // Round-robin streaming with all consumers ready
    IN_VALID = 1'b1; AUTO = 1'b1; OUT_READY = 4'hF;
    for (int k = 0; k < 6; k++) begin
      D_IN = 8'hA0 + 8'(k);
      step();
      ch = 2'(k % 4);
      rr_exp = 8'hA0 + 8'(k);
      check("rr_valid", {60'd0, OUT_VALID}, 64'(4'b0001 << ch));
      check("rr_dout", {56'd0, (ch == 2'd0) ? D_OUT0 : (ch == 2'd1) ? D_OUT1 :
                               (ch == 2'd2) ? D_OUT2 : D_OUT3}, {56'd0, rr_exp});
    end
    check("rr_ptr", {62'd0, RR_PTR}, 64'd2);
    check("rr_cnt", {32'd0, CNT}, 64'h02030303);
    check("rr_dout_all", {32'd0, D_OUT3, D_OUT2, D_OUT1, D_OUT0}, 64'hA3A2A5A4);

    // Walk pointer to 1, leaving only channel 1 full and stalled
    OUT_READY = 4'h0;
    D_IN = 8'hB2; step();
    D_IN = 8'hB3; step();
    D_IN = 8'hB0; step();
    check("st_ptr_walk", {62'd0, RR_PTR}, 64'd1);
    check("st_valid_full", {60'd0, OUT_VALID}, 64'hF);
    IN_VALID = 1'b0; OUT_READY = 4'b1101;
    step();
    check("st_valid_ch1", {60'd0, OUT_VALID}, 64'h2);
    OUT_READY = 4'h0; IN_VALID = 1'b1; D_IN = 8'hBB;
    #1;
    check("st_rdy", {63'd0, IN_READY}, 64'd0);
    step();
    check("st_ptr_hold", {62'd0, RR_PTR}, 64'd1);
    check("st_cnt_hold", {32'd0, CNT}, 64'h03040304);
    AUTO = 1'b0; SEL = 2'd3; D_IN = 8'hC3;
    #1;
    check("ms_rdy", {63'd0, IN_READY}, 64'd1);
    step();
    check("ms_dout3", {56'd0, D_OUT3}, 64'hC3);
    check("ms_ptr", {62'd0, RR_PTR}, 64'd1);
    check("ms_valid", {60'd0, OUT_VALID}, 64'hA);
    check("ms_cnt", {32'd0, CNT}, 64'h04040304);

    // Fill all slots then assert reset between edges
    SEL = 2'd0; D_IN = 8'hD0; step();
    SEL = 2'd2; D_IN = 8'hD2; step();
    IN_VALID = 1'b0;
    check("ar_pre_valid", {60'd0, OUT_VALID}, 64'hF);
    #3;
    RST_N = 1'b0;
    #1;
    check("ar_valid", {60'd0, OUT_VALID}, 64'h0);
    check("ar_dout", {32'd0, D_OUT3, D_OUT2, D_OUT1, D_OUT0}, 64'h0);
    check("ar_cnt", {32'd0, CNT}, 64'h0);
    check("ar_ptr", {62'd0, RR_PTR}, 64'd1 - 64'd1);
    check("ar_rdy", {63'd0, IN_READY}, 64'd0);
    step();
    RST_N = 1'b1;

    // Counter wrap on channel 0
    AUTO = 1'b0; SEL = 2'd0; OUT_READY = 4'h1; IN_VALID = 1'b1;
    for (int k = 0; k < 256; k++) begin
      D_IN = 8'(k);
      step();
      if (k == 0) check("wr_first", {32'd0, CNT}, 64'h00000001);
      if (k == 254) check("wr_ff", {32'd0, CNT}, 64'h000000FF);
    end
    IN_VALID = 1'b0;
    check("wr_cnt", {32'd0, CNT}, 64'h0);
    check("wr_dout0", {56'd0, D_OUT0}, 64'hFF);
    check("wr_valid", {60'd0, OUT_VALID}, 64'h1);
    step();
    check("wr_drained", {60'd0, OUT_VALID}, 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
